// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit.
//   SIZE_*      : request size encodings (2'b11 is treated as a word)
//   state_e     : access controller FSM states
//   LANE_OFF*   : big-endian byte-lane offsets (offset 0 = bits [31:24])
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

  localparam logic [1:0] LANE_OFF0 = 2'd0;
  localparam logic [1:0] LANE_OFF1 = 2'd1;
  localparam logic [1:0] LANE_OFF2 = 2'd2;
  localparam logic [1:0] LANE_OFF3 = 2'd3;

endpackage

// File: rtl/mem_access_unit_if.sv
// Bus bundle between the pipeline / data memory and mem_access_unit.
//   req_*   : load/store request from the EX/MEM register
//   stall   : hold the EX/MEM register
//   resp_*  : one-cycle response with load data and error flags
//   mem_*   : word-wide, big-endian data memory port
// modport slave  : the access unit
// modport master : pipeline + data memory side
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_misalign;
  logic              resp_range;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_writeData;
  logic              mem_memWrite;
  logic              mem_memRead;
  logic [31:0]       mem_readData;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_readData,
    output stall, resp_valid, resp_rdata, resp_misalign, resp_range,
    output mem_address, mem_writeData, mem_memWrite, mem_memRead
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_readData,
    input  stall, resp_valid, resp_rdata, resp_misalign, resp_range,
    input  mem_address, mem_writeData, mem_memWrite, mem_memRead
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational big-endian lane steering.
//   word_i     : memory word
//   data_i     : store data (sub-word data in low bits)
//   offset_i   : byte offset addr[1:0]
//   size_i     : request size
//   unsigned_i : zero-extend loads when 1
//   load_o     : selected lane, sign/zero extended
//   store_o    : word_i with data_i merged into the selected lane
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[31:24];
    case (offset_i)
      LANE_OFF0: byte_sel = word_i[31:24];
      LANE_OFF1: byte_sel = word_i[23:16];
      LANE_OFF2: byte_sel = word_i[15:8];
      LANE_OFF3: byte_sel = word_i[7:0];
      default:   byte_sel = word_i[31:24];
    endcase
    half_sel = offset_i[1] ? word_i[15:0] : word_i[31:16];

    case (size_i)
      SIZE_BYTE: load_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default:   load_o = word_i;
    endcase
  end

  always_comb begin
    store_o = word_i;
    case (size_i)
      SIZE_BYTE: begin
        case (offset_i)
          LANE_OFF0: store_o[31:24] = data_i[7:0];
          LANE_OFF1: store_o[23:16] = data_i[7:0];
          LANE_OFF2: store_o[15:8]  = data_i[7:0];
          LANE_OFF3: store_o[7:0]   = data_i[7:0];
          default:   store_o        = word_i;
        endcase
      end
      SIZE_HALF: begin
        if (offset_i[1]) store_o[15:0]  = data_i[15:0];
        else             store_o[31:16] = data_i[15:0];
      end
      default: store_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access controller.
//   clk, rst_n : pipeline clock, async active-low reset
//   bus        : request / response / data-memory bundle (slave side)
// Loads and word stores complete in one cycle. Sub-word stores read the
// word in IDLE (stalling), merge, then write the held word in RMW_WR.
// Misaligned or out-of-range requests make no memory access and return
// an error response the next cycle.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128,
  parameter int unsigned ADDR_W    = 32
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_e state_q, state_d;

  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_misalign_q, resp_misalign_d;
  logic              resp_range_q, resp_range_d;
  logic [ADDR_W-3:0] hold_waddr_q, hold_waddr_d;
  logic [31:0]       hold_word_q, hold_word_d;

  logic        is_byte, is_half, is_word;
  logic [2:0]  last_off;
  logic [ADDR_W:0] end_addr;
  logic        misalign, out_of_range, req_err;
  logic        req_ok, do_load, do_word_st, do_sub_st;
  logic [31:0] load_data, merged_word;

  mem_lane_align u_align (
    .word_i     (bus.mem_readData),
    .data_i     (bus.req_wdata),
    .offset_i   (bus.req_addr[1:0]),
    .size_i     (bus.req_size),
    .unsigned_i (bus.req_unsigned),
    .load_o     (load_data),
    .store_o    (merged_word)
  );

  // Request classification; only meaningful in IDLE.
  always_comb begin
    is_byte  = (bus.req_size == SIZE_BYTE);
    is_half  = (bus.req_size == SIZE_HALF);
    is_word  = !is_byte && !is_half;
    last_off = is_byte ? 3'd0 : (is_half ? 3'd1 : 3'd3);
    // One extra bit so addresses near the top of the space cannot wrap.
    end_addr = {1'b0, bus.req_addr} + {{(ADDR_W-2){1'b0}}, last_off};
    misalign     = (is_half && bus.req_addr[0]) ||
                   (is_word && (bus.req_addr[1:0] != 2'b00));
    out_of_range = (end_addr >= MEM_LIMIT);
    req_err      = misalign || out_of_range;
    req_ok       = (state_q == IDLE) && bus.req_valid && !req_err;
    do_load      = req_ok && !bus.req_write;
    do_word_st   = req_ok && bus.req_write && is_word;
    do_sub_st    = req_ok && bus.req_write && !is_word;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (do_sub_st) state_d = RMW_WR;
      RMW_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory port and stall, combinational from state and request
  always_comb begin
    bus.stall         = 1'b0;
    bus.mem_memRead   = 1'b0;
    bus.mem_memWrite  = 1'b0;
    bus.mem_address   = '0;
    bus.mem_writeData = '0;
    case (state_q)
      IDLE: begin
        if (do_load || do_sub_st) begin
          bus.mem_memRead = 1'b1;
          bus.mem_address = {bus.req_addr[ADDR_W-1:2], 2'b00};
          bus.stall       = do_sub_st;
        end else if (do_word_st) begin
          bus.mem_memWrite  = 1'b1;
          bus.mem_address   = {bus.req_addr[ADDR_W-1:2], 2'b00};
          bus.mem_writeData = bus.req_wdata;
        end
      end
      RMW_WR: begin
        bus.mem_memWrite  = 1'b1;
        bus.mem_address   = {hold_waddr_q, 2'b00};
        bus.mem_writeData = hold_word_q;
      end
      default: ;
    endcase
  end

  // Response and held-request next values
  always_comb begin
    resp_valid_d    = 1'b0;
    resp_rdata_d    = resp_rdata_q;
    resp_misalign_d = 1'b0;
    resp_range_d    = 1'b0;
    hold_waddr_d    = hold_waddr_q;
    hold_word_d     = hold_word_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err) begin
            resp_valid_d    = 1'b1;
            resp_rdata_d    = '0;
            resp_misalign_d = misalign;
            resp_range_d    = out_of_range;
          end else if (!bus.req_write) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = load_data;
          end else if (is_word) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
          end else begin
            hold_waddr_d = bus.req_addr[ADDR_W-1:2];
            hold_word_d  = merged_word;
          end
        end
      end
      RMW_WR: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_misalign_q <= 1'b0;
      resp_range_q    <= 1'b0;
      hold_waddr_q    <= '0;
      hold_word_q     <= '0;
    end else begin
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_misalign_q <= resp_misalign_d;
      resp_range_q    <= resp_range_d;
      hold_waddr_q    <= hold_waddr_d;
      hold_word_q     <= hold_word_d;
    end
  end

  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.resp_misalign = resp_misalign_q;
  assign bus.resp_range    = resp_range_q;

endmodule
